// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select codes
// and the register number that is never forwarded (the PC).
package hazard_unit_pkg;

   localparam logic [2:0] FWD_RF   = 3'b000;
   localparam logic [2:0] FWD_RESW = 3'b001;
   localparam logic [2:0] FWD_ALUM = 3'b010;
   localparam logic [2:0] FWD_HIM  = 3'b011;
   localparam logic [2:0] FWD_HIW  = 3'b100;

   localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/ff1to1.sv
// Plain register block with asynchronous active-high reset; loads every cycle.
module ff1to1 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority select: newest producer wins, PC never forwarded.
module hazard_fwd_sel
   import hazard_unit_pkg::*;
#(
   parameter int unsigned RW = 4
) (
   input  logic [RW-1:0] raE,
   input  logic          regWriteM,
   input  logic          regWrite2M,
   input  logic          regWriteW,
   input  logic          regWrite2W,
   input  logic [RW-1:0] wa3M,
   input  logic [RW-1:0] wa4M,
   input  logic [RW-1:0] wa3W,
   input  logic [RW-1:0] wa4W,
   output logic [2:0]    fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (raE != RW'(PC_REG)) begin
         if (regWriteM && (raE == wa3M))       fwd = FWD_ALUM;
         else if (regWrite2M && (raE == wa4M)) fwd = FWD_HIM;
         else if (regWriteW && (raE == wa3W))  fwd = FWD_RESW;
         else if (regWrite2W && (raE == wa4W)) fwd = FWD_HIW;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, PC-write/branch flush, operand
// forwarding, and a saturating count of stalled decode cycles.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned RW = 4,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] RA1D,
   input  logic [RW-1:0] RA2D,
   input  logic [RW-1:0] WA3D,
   input  logic [RW-1:0] WA4D,
   input  logic          RegWriteE,
   input  logic          MemToRegE,
   input  logic          RegWriteM,
   input  logic          RegWrite2M,
   input  logic          RegWriteW,
   input  logic          RegWrite2W,
   input  logic          PCSrcD,
   input  logic          PCSrcE,
   input  logic          PCSrcM,
   input  logic          PCSrcW,
   input  logic          BranchTakenE,
   output logic          StallF,
   output logic          StallD,
   output logic          FlushD,
   output logic          FlushE,
   output logic [2:0]    ForwardAE,
   output logic [2:0]    ForwardBE,
   output logic [CW-1:0] StallCount
);

   logic          resetHigh;
   logic [RW-1:0] RA1E, RA2E, WA3E, WA4E;
   logic [RW-1:0] WA3M, WA4M, WA3W, WA4W;
   logic [4*RW-1:0] deD, deQ;
   logic [2*RW-1:0] emQ, mwQ;
   logic          ldrStall, pcWrPending;
   logic [CW-1:0] stallCountQ, stallCountD;

   assign resetHigh = ~reset;

   // A flushed execute stage becomes a bubble with all-zero addresses.
   assign deD = FlushE ? '0 : {RA1D, RA2D, WA3D, WA4D};

   ff1to1 #(.W(4*RW)) deReg (
      .clk   (clk),
      .reset (resetHigh),
      .d     (deD),
      .q     (deQ)
   );
   assign {RA1E, RA2E, WA3E, WA4E} = deQ;

   ff1to1 #(.W(2*RW)) emReg (
      .clk   (clk),
      .reset (resetHigh),
      .d     ({WA3E, WA4E}),
      .q     (emQ)
   );
   assign {WA3M, WA4M} = emQ;

   ff1to1 #(.W(2*RW)) mwReg (
      .clk   (clk),
      .reset (resetHigh),
      .d     ({WA3M, WA4M}),
      .q     (mwQ)
   );
   assign {WA3W, WA4W} = mwQ;

   hazard_fwd_sel #(.RW(RW)) fwdA (
      .raE        (RA1E),
      .regWriteM  (RegWriteM),
      .regWrite2M (RegWrite2M),
      .regWriteW  (RegWriteW),
      .regWrite2W (RegWrite2W),
      .wa3M       (WA3M),
      .wa4M       (WA4M),
      .wa3W       (WA3W),
      .wa4W       (WA4W),
      .fwd        (ForwardAE)
   );

   hazard_fwd_sel #(.RW(RW)) fwdB (
      .raE        (RA2E),
      .regWriteM  (RegWriteM),
      .regWrite2M (RegWrite2M),
      .regWriteW  (RegWriteW),
      .regWrite2W (RegWrite2W),
      .wa3M       (WA3M),
      .wa4M       (WA4M),
      .wa3W       (WA3W),
      .wa4W       (WA4W),
      .fwd        (ForwardBE)
   );

   always_comb begin
      ldrStall    = MemToRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
      pcWrPending = PCSrcD || PCSrcE || PCSrcM;
      StallF      = ldrStall || pcWrPending;
      StallD      = ldrStall;
      FlushD      = pcWrPending || PCSrcW || BranchTakenE;
      FlushE      = ldrStall || BranchTakenE;
   end

   always_comb begin
      stallCountD = stallCountQ;
      if (StallD && (stallCountQ != '1)) stallCountD = stallCountQ + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stallCountQ <= '0;
      else        stallCountQ <= stallCountD;
   end

   assign StallCount = stallCountQ;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random stimulus
// against a stage-list reference model.
module tb_hazard_unit;

   localparam int RW = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [RW-1:0] RA1D, RA2D, WA3D, WA4D;
   logic          RegWriteE, MemToRegE, RegWriteM, RegWrite2M, RegWriteW, RegWrite2W;
   logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [2:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] StallCount;

   hazard_unit #(.RW(RW), .CW(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .RA1D         (RA1D),
      .RA2D         (RA2D),
      .WA3D         (WA3D),
      .WA4D         (WA4D),
      .RegWriteE    (RegWriteE),
      .MemToRegE    (MemToRegE),
      .RegWriteM    (RegWriteM),
      .RegWrite2M   (RegWrite2M),
      .RegWriteW    (RegWriteW),
      .RegWrite2W   (RegWrite2W),
      .PCSrcD       (PCSrcD),
      .PCSrcE       (PCSrcE),
      .PCSrcM       (PCSrcM),
      .PCSrcW       (PCSrcW),
      .BranchTakenE (BranchTakenE),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .ForwardAE    (ForwardAE),
      .ForwardBE    (ForwardBE),
      .StallCount   (StallCount)
   );

   always #5 clk = ~clk;

   int nTests = 0;
   int nFail  = 0;

   // Reference model: address contents of each stage, stall counter.
   int eA[4];   // RA1, RA2, WA3, WA4 in execute
   int mA[2];   // WA3, WA4 in memory
   int wA[2];   // WA3, WA4 in writeback
   int mCount;
   int maxCount = (1 << CW) - 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) eA[i] = 0;
      for (int i = 0; i < 2; i++) begin mA[i] = 0; wA[i] = 0; end
      mCount = 0;
   endtask

   function automatic int fwdOf(int ra);
      bit en[4];
      int addr[4];
      int code[4];
      en   = '{RegWriteM, RegWrite2M, RegWriteW, RegWrite2W};
      addr = '{mA[0], mA[1], wA[0], wA[1]};
      code = '{2, 3, 1, 4};
      if (ra == 15) return 0;
      for (int i = 0; i < 4; i++) if (en[i] && addr[i] == ra) return code[i];
      return 0;
   endfunction

   function automatic bit loadUse();
      return MemToRegE && RegWriteE && (int'(RA1D) == eA[2] || int'(RA2D) == eA[2]);
   endfunction

   task automatic settle();
      bit ldr, pcw;
      #3;
      ldr = loadUse();
      pcw = PCSrcD || PCSrcE || PCSrcM;
      check("StallF", 32'(StallF), 32'(ldr || pcw));
      check("StallD", 32'(StallD), 32'(ldr));
      check("FlushD", 32'(FlushD), 32'(pcw || PCSrcW || BranchTakenE));
      check("FlushE", 32'(FlushE), 32'(ldr || BranchTakenE));
      check("ForwardAE", 32'(ForwardAE), 32'(fwdOf(eA[0])));
      check("ForwardBE", 32'(ForwardBE), 32'(fwdOf(eA[1])));
      check("StallCount", 32'(StallCount), 32'(mCount));
   endtask

   task automatic tick();
      bit ldr, flushE;
      ldr    = loadUse();
      flushE = ldr || BranchTakenE;
      @(posedge clk);
      if (ldr && mCount < maxCount) mCount++;
      wA = mA;
      mA = '{eA[2], eA[3]};
      if (flushE) eA = '{0, 0, 0, 0};
      else eA = '{int'(RA1D), int'(RA2D), int'(WA3D), int'(WA4D)};
      #1;
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   task automatic clearIn();
      {RA1D, RA2D, WA3D, WA4D} = '0;
      {RegWriteE, MemToRegE, RegWriteM, RegWrite2M, RegWriteW, RegWrite2W} = '0;
      {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
   endtask

   function automatic logic [RW-1:0] pickReg();
      if ($urandom_range(0, 9) < 8) return RW'($urandom_range(0, 3));
      return $urandom_range(0, 1) ? RW'(15) : RW'($urandom_range(0, 15));
   endfunction

   task automatic randIn();
      RA1D = pickReg(); RA2D = pickReg(); WA3D = pickReg(); WA4D = pickReg();
      RegWriteE  = 1'($urandom_range(0, 1));
      MemToRegE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWrite2M = 1'($urandom_range(0, 3) == 0);
      RegWriteW  = 1'($urandom_range(0, 1));
      RegWrite2W = 1'($urandom_range(0, 3) == 0);
      PCSrcD = 1'($urandom_range(0, 7) == 0);
      PCSrcE = 1'($urandom_range(0, 7) == 0);
      PCSrcM = 1'($urandom_range(0, 7) == 0);
      PCSrcW = 1'($urandom_range(0, 7) == 0);
      BranchTakenE = 1'($urandom_range(0, 5) == 0);
   endtask

   initial begin
      clearIn();
      modelReset();
      #2;
      check("rstStallF", 32'(StallF), 0);
      check("rstStallD", 32'(StallD), 0);
      check("rstFlushD", 32'(FlushD), 0);
      check("rstFlushE", 32'(FlushE), 0);
      check("rstFwdA", 32'(ForwardAE), 0);
      check("rstFwdB", 32'(ForwardBE), 0);
      check("rstCount", 32'(StallCount), 0);
      #1 reset = 1'b1;
      tick();
      cyc();

      // ALU result forwarded from memory stage
      clearIn(); WA3D = 3; cyc();
      clearIn(); RA1D = 3; cyc();
      clearIn(); RegWriteM = 1; settle();
      check("aluFwdM", 32'(ForwardAE), 32'(3'b010)); tick();

      // Same hazard one cycle further apart -> writeback forward
      clearIn(); WA3D = 3; cyc();
      clearIn(); cyc();
      clearIn(); RA1D = 3; cyc();
      clearIn(); RegWriteW = 1; settle();
      check("resFwdW", 32'(ForwardAE), 32'(3'b001)); tick();

      // Load-use stall on RA2D
      clearIn(); WA3D = 5; cyc();
      clearIn(); RA2D = 5; MemToRegE = 1; RegWriteE = 1; settle();
      check("luStallF", 32'(StallF), 1);
      check("luStallD", 32'(StallD), 1);
      check("luFlushE", 32'(FlushE), 1);
      tick();
      clearIn(); RA2D = 5; RegWriteM = 1; settle();
      check("luReleased", 32'(StallD), 0);
      check("luCount", 32'(StallCount), 1);
      tick();
      clearIn(); RegWriteW = 1; settle();
      check("luFwdB", 32'(ForwardBE), 32'(3'b001)); tick();

      // PC write travelling D -> E -> M -> W
      for (int c = 0; c < 5; c++) begin
         clearIn();
         PCSrcD = (c == 0); PCSrcE = (c == 1); PCSrcM = (c == 2); PCSrcW = (c == 3);
         settle();
         check("pcStallF", 32'(StallF), 32'(c <= 2));
         check("pcFlushD", 32'(FlushD), 32'(c <= 3));
         tick();
      end

      // Branch taken together with load-use
      clearIn(); WA3D = 6; cyc();
      clearIn(); RA1D = 6; MemToRegE = 1; RegWriteE = 1; BranchTakenE = 1; settle();
      check("brFlushD", 32'(FlushD), 1);
      check("brFlushE", 32'(FlushE), 1);
      check("brStallD", 32'(StallD), 1);
      tick();
      clearIn(); RegWriteM = 1; settle();
      check("brNoFwdA", 32'(ForwardAE), 0);
      check("brNoFwdB", 32'(ForwardBE), 0);
      tick();

      // Long multiply high half beats older writeback low half
      clearIn(); WA3D = 7; cyc();
      clearIn(); WA4D = 7; cyc();
      clearIn(); RA1D = 7; cyc();
      clearIn(); RegWrite2M = 1; RegWriteW = 1; settle();
      check("hiFwdM", 32'(ForwardAE), 32'(3'b011)); tick();

      // PC register is never forwarded
      clearIn(); WA3D = 15; cyc();
      clearIn(); WA4D = 15; cyc();
      clearIn(); RA1D = 15; cyc();
      clearIn(); RegWrite2M = 1; RegWriteW = 1; RegWriteM = 1; settle();
      check("pcNoFwd", 32'(ForwardAE), 0); tick();

      // Asynchronous reset in the middle of a stall
      clearIn(); WA3D = 5; cyc();
      clearIn(); RA1D = 9; RA2D = 5; MemToRegE = 1; RegWriteE = 1; settle();
      check("preRstStall", 32'(StallD), 1);
      #1 reset = 1'b0;
      modelReset();
      #1;
      check("midRstStallD", 32'(StallD), 0);
      check("midRstFlushE", 32'(FlushE), 0);
      check("midRstCount", 32'(StallCount), 0);
      reset = 1'b1;
      tick();

      // Continuous stall until the counter saturates
      clearIn(); MemToRegE = 1; RegWriteE = 1;
      repeat ((1 << CW) + 5) cyc();
      settle();
      check("satCount", 32'(StallCount), 32'((1 << CW) - 1));
      tick();

      // Random stimulus with occasional asynchronous reset pulses
      for (int i = 0; i < 3000; i++) begin
         randIn();
         if (i % 250 == 125) begin
            #1 reset = 1'b0;
            modelReset();
            #1 reset = 1'b1;
            settle();
            #2;
         end else begin
            settle();
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
